// File: rtl/vga_tile_display.sv
// vga_tile_display
//   Avalon-MM slave that scans a GRID_W x GRID_H tile map onto a VGA raster.
//   Each cell holds a TILE_BITS code; code 0 shows the background colour,
//   any other code indexes the palette. Background and palette are written
//   into shadow copies and become live together at the start of vertical blank.
//
// Ports
//   clk, reset            system clock, asynchronous active-high reset
//   chipselect/write/read Avalon strobes; address selects a register
//   writedata/readdata    8-bit data; readdata is valid the cycle after read
//   frame_tick            one-clk pulse when the raster enters vertical blank
//   VGA_R/G/B             pixel colour, 2 clk behind the raster counters
//   VGA_CLK/HS/VS/BLANK_n/SYNC_n  VGA control
module vga_tile_display #(
    parameter int TILE_SHIFT = 4,
    parameter int GRID_W     = 40,
    parameter int GRID_H     = 30,
    parameter int TILE_BITS  = 3,
    parameter int H_ACTIVE   = 1280,
    parameter int H_FP       = 32,
    parameter int H_SYNC     = 192,
    parameter int H_BP       = 96,
    parameter int V_ACTIVE   = 480,
    parameter int V_FP       = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BP       = 33
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       chipselect,
    input  logic       write,
    input  logic       read,
    input  logic [3:0] address,
    input  logic [7:0] writedata,
    output logic [7:0] readdata,
    output logic       frame_tick,
    output logic [7:0] VGA_R,
    output logic [7:0] VGA_G,
    output logic [7:0] VGA_B,
    output logic       VGA_CLK,
    output logic       VGA_HS,
    output logic       VGA_VS,
    output logic       VGA_BLANK_n,
    output logic       VGA_SYNC_n
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);
    localparam int NCELL   = GRID_W * GRID_H;
    localparam int AW      = (NCELL > 1) ? $clog2(NCELL) : 1;
    localparam int NPAL    = 2 ** TILE_BITS;

    function automatic logic [23:0] pal_default(input int k);
        return {((k % 2) == 1)       ? 8'hFF : 8'h00,
                (((k / 2) % 2) == 1) ? 8'hFF : 8'h00,
                (((k / 4) % 2) == 1) ? 8'hFF : 8'h00};
    endfunction

    // Raster counters
    logic [HW-1:0] r_hcount;
    logic [VW-1:0] r_vcount;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_hcount <= '0;
            r_vcount <= '0;
        end else if (r_hcount == HW'(H_TOTAL - 1)) begin
            r_hcount <= '0;
            r_vcount <= (r_vcount == VW'(V_TOTAL - 1)) ? '0 : r_vcount + VW'(1);
        end else begin
            r_hcount <= r_hcount + HW'(1);
        end
    end

    logic w_blank_n, w_hs, w_vs, w_commit, w_in_vblank;
    assign w_blank_n   = (r_hcount < HW'(H_ACTIVE)) && (r_vcount < VW'(V_ACTIVE));
    assign w_hs        = !((r_hcount >= HW'(H_ACTIVE + H_FP)) &&
                           (r_hcount <  HW'(H_ACTIVE + H_FP + H_SYNC)));
    assign w_vs        = !((r_vcount >= VW'(V_ACTIVE + V_FP)) &&
                           (r_vcount <  VW'(V_ACTIVE + V_FP + V_SYNC)));
    assign w_commit    = (r_hcount == '0) && (r_vcount == VW'(V_ACTIVE));
    assign w_in_vblank = (r_vcount >= VW'(V_ACTIVE));

    // Tile under the beam: each pixel lasts 2 clk, hence the extra shift.
    logic [HW-1:0] w_col;
    logic [VW-1:0] w_row;
    logic          w_in_grid;
    logic [AW-1:0] w_rd_addr;
    assign w_col     = r_hcount >> (TILE_SHIFT + 1);
    assign w_row     = r_vcount >> TILE_SHIFT;
    assign w_in_grid = (w_col < HW'(GRID_W)) && (w_row < VW'(GRID_H));
    assign w_rd_addr = w_in_grid ? AW'(int'(w_row) * GRID_W + int'(w_col)) : '0;

    // Bus decode
    logic [7:0] r_cursor_x, r_cursor_y;
    logic       w_wr, w_rd, w_cur_ok, w_map_we;
    logic [AW-1:0] w_wr_addr;
    assign w_wr      = chipselect && write;
    assign w_rd      = chipselect && read;
    assign w_cur_ok  = (int'(r_cursor_x) < GRID_W) && (int'(r_cursor_y) < GRID_H);
    assign w_map_we  = w_wr && (address == 4'd5) && w_cur_ok;
    assign w_wr_addr = AW'(int'(r_cursor_y) * GRID_W + int'(r_cursor_x));

    // Tile map: one write port (bus), one read port (raster). A collision
    // returns the old contents because the read samples before the write lands.
    logic [TILE_BITS-1:0] r_map [NCELL];
    logic [TILE_BITS-1:0] r_tile;

    // NOTE: the map has no reset; software clears it, and resetting a RAM
    // would prevent it from mapping onto block memory.
    always_ff @(posedge clk) begin
        if (w_map_we) r_map[w_wr_addr] <= writedata[TILE_BITS-1:0];
        r_tile <= r_map[w_rd_addr];
    end

    // Cursor with auto-increment; an out-of-range cursor snaps back to (0,0).
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cursor_x <= '0;
            r_cursor_y <= '0;
        end else if (w_wr) begin
            case (address)
                4'd3: r_cursor_x <= writedata;
                4'd4: r_cursor_y <= writedata;
                4'd5: begin
                    if (!w_cur_ok) begin
                        r_cursor_x <= '0;
                        r_cursor_y <= '0;
                    end else if (int'(r_cursor_x) == GRID_W - 1) begin
                        r_cursor_x <= '0;
                        r_cursor_y <= (int'(r_cursor_y) == GRID_H - 1) ? 8'd0
                                                                       : r_cursor_y + 8'd1;
                    end else begin
                        r_cursor_x <= r_cursor_x + 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Shadow and live colour registers; live copies change only at commit,
    // which falls in blanking, so a frame never mixes old and new colours.
    logic [TILE_BITS-1:0] r_pal_idx;
    logic [23:0]          r_bg_sh, r_bg_lv;
    logic [23:0]          r_pal_sh [NPAL];
    logic [23:0]          r_pal_lv [NPAL];
    logic [6:0]           r_frame_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pal_idx <= '0;
            r_bg_sh   <= 24'h000080;
            for (int k = 0; k < NPAL; k++) r_pal_sh[k] <= pal_default(k);
        end else if (w_wr) begin
            case (address)
                4'd0: r_bg_sh[23:16] <= writedata;
                4'd1: r_bg_sh[15:8]  <= writedata;
                4'd2: r_bg_sh[7:0]   <= writedata;
                4'd6: r_pal_idx      <= writedata[TILE_BITS-1:0];
                4'd7: r_pal_sh[r_pal_idx][23:16] <= writedata;
                4'd8: r_pal_sh[r_pal_idx][15:8]  <= writedata;
                4'd9: r_pal_sh[r_pal_idx][7:0]   <= writedata;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_bg_lv     <= 24'h000080;
            r_frame_cnt <= '0;
            for (int k = 0; k < NPAL; k++) r_pal_lv[k] <= pal_default(k);
        end else if (w_commit) begin
            r_bg_lv     <= r_bg_sh;
            r_frame_cnt <= r_frame_cnt + 7'd1;
            for (int k = 0; k < NPAL; k++) r_pal_lv[k] <= r_pal_sh[k];
        end
    end

    assign frame_tick = w_commit;

    // Read path
    logic [7:0] w_rd_mux;
    always_comb begin
        // NOTE: default first so every path assigns and no latch is inferred.
        w_rd_mux = 8'h00;
        case (address)
            4'd10:   w_rd_mux = {r_frame_cnt, w_in_vblank};
            4'd11:   w_rd_mux = r_cursor_x;
            4'd12:   w_rd_mux = r_cursor_y;
            default: w_rd_mux = 8'h00;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)     readdata <= 8'h00;
        else if (w_rd) readdata <= w_rd_mux;
    end

    // Pixel pipeline: stage 1 is the map read, stage 2 the colour lookup.
    // Sync and blank travel alongside so they stay aligned with RGB.
    logic                 r_in_grid_d1, r_bn_d1, r_hs_d1, r_vs_d1;
    logic                 r_bn_d2, r_hs_d2, r_vs_d2;
    logic [23:0]          r_rgb;
    logic [TILE_BITS-1:0] w_code;
    logic [23:0]          w_color;
    assign w_code  = r_in_grid_d1 ? r_tile : '0;
    assign w_color = (w_code == '0) ? r_bg_lv : r_pal_lv[w_code];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_in_grid_d1 <= 1'b0;
            r_bn_d1      <= 1'b0;
            r_hs_d1      <= 1'b1;
            r_vs_d1      <= 1'b1;
            r_bn_d2      <= 1'b0;
            r_hs_d2      <= 1'b1;
            r_vs_d2      <= 1'b1;
            r_rgb        <= '0;
        end else begin
            r_in_grid_d1 <= w_in_grid;
            r_bn_d1      <= w_blank_n;
            r_hs_d1      <= w_hs;
            r_vs_d1      <= w_vs;
            r_bn_d2      <= r_bn_d1;
            r_hs_d2      <= r_hs_d1;
            r_vs_d2      <= r_vs_d1;
            r_rgb        <= r_bn_d1 ? w_color : 24'h0;
        end
    end

    assign VGA_R       = r_rgb[23:16];
    assign VGA_G       = r_rgb[15:8];
    assign VGA_B       = r_rgb[7:0];
    assign VGA_HS      = r_hs_d2;
    assign VGA_VS      = r_vs_d2;
    assign VGA_BLANK_n = r_bn_d2;
    assign VGA_CLK     = r_hcount[0];
    assign VGA_SYNC_n  = 1'b0;

endmodule

// File: tb/tb_vga_tile_display.sv
// Testbench for vga_tile_display, run on a shrunken raster so many frames fit
// in a short simulation. A frame-level reference model predicts every pixel,
// the sync/tick outputs and each register read; a monitor compares them.
module tb_vga_tile_display;
    localparam int TS  = 1;
    localparam int GW  = 3;
    localparam int GH  = 3;
    localparam int TB  = 3;
    localparam int HA  = 16;
    localparam int HF  = 2;
    localparam int HSY = 4;
    localparam int HB  = 2;
    localparam int VA  = 8;
    localparam int VF  = 1;
    localparam int VSY = 2;
    localparam int VB  = 1;
    localparam int HT  = HA + HF + HSY + HB;
    localparam int VT  = VA + VF + VSY + VB;
    localparam int NP  = 1 << TB;
    localparam int TPX = 1 << TS;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       chipselect = 1'b0, write = 1'b0, read = 1'b0;
    logic [3:0] address = '0;
    logic [7:0] writedata = '0;
    logic [7:0] readdata;
    logic       frame_tick;
    logic [7:0] VGA_R, VGA_G, VGA_B;
    logic       VGA_CLK, VGA_HS, VGA_VS, VGA_BLANK_n, VGA_SYNC_n;

    vga_tile_display #(
        .TILE_SHIFT(TS), .GRID_W(GW), .GRID_H(GH), .TILE_BITS(TB),
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSY), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSY), .V_BP(VB)
    ) dut (
        .clk(clk), .reset(reset), .chipselect(chipselect), .write(write),
        .read(read), .address(address), .writedata(writedata),
        .readdata(readdata), .frame_tick(frame_tick),
        .VGA_R(VGA_R), .VGA_G(VGA_G), .VGA_B(VGA_B), .VGA_CLK(VGA_CLK),
        .VGA_HS(VGA_HS), .VGA_VS(VGA_VS), .VGA_BLANK_n(VGA_BLANK_n),
        .VGA_SYNC_n(VGA_SYNC_n)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Scoreboard entries
    typedef struct {
        int          cyc;
        logic [23:0] rgb;
        logic        hs, vs, bn, ft, vclk, chk;
    } pix_t;
    typedef struct {
        int         due;
        int         a;
        logic [7:0] data;
    } rd_t;
    pix_t pix_q[$];
    rd_t  rd_q[$];
    int   cyc    = 0;
    bit   mon_en = 0;

    // Reference model state
    int          mh, mv, fc, cx, cy, pidx;
    logic [23:0] bg_sh, bg_lv;
    logic [23:0] pal_sh [NP];
    logic [23:0] pal_lv [NP];
    int          tmap   [GH][GW];
    bit          tknown [GH][GW];

    task automatic model_reset();
        mh = 0; mv = 0; fc = 0; cx = 0; cy = 0; pidx = 0;
        bg_sh = 24'h000080;
        bg_lv = 24'h000080;
        for (int k = 0; k < NP; k++) begin
            pal_sh[k] = {8'(255 * (k % 2)), 8'(255 * ((k / 2) % 2)), 8'(255 * ((k / 4) % 2))};
            pal_lv[k] = pal_sh[k];
        end
        for (int y = 0; y < GH; y++)
            for (int x = 0; x < GW; x++) tknown[y][x] = 0;
    endtask

    // One clock of stimulus: predict outputs for the current raster position,
    // apply the bus operation to the model, and drive the DUT.
    task automatic step(input bit do_wr, input bit do_rd, input int a, input int d);
        pix_t e;
        rd_t  r;
        int   code, tx, ty;
        bit   act;
        act    = (mh < HA) && (mv < VA);
        e.cyc  = cyc;
        e.hs   = !((mh >= HA + HF) && (mh < HA + HF + HSY));
        e.vs   = !((mv >= VA + VF) && (mv < VA + VF + VSY));
        e.bn   = act;
        e.ft   = (mh == 0) && (mv == VA);
        e.vclk = (mh % 2) == 1;
        e.chk  = 1;
        e.rgb  = 24'h0;
        if (act) begin
            tx = (mh / 2) / TPX;
            ty = mv / TPX;
            code = 0;
            if (tx < GW && ty < GH) begin
                if (!tknown[ty][tx]) e.chk = 0;
                else code = tmap[ty][tx];
            end
            e.rgb = (code == 0) ? bg_lv : pal_lv[code];
        end
        pix_q.push_back(e);

        if (do_rd) begin
            r.due = cyc + 1;
            r.a   = a;
            case (a)
                10:      r.data = 8'((fc % 128) * 2 + ((mv >= VA) ? 1 : 0));
                11:      r.data = 8'(cx);
                12:      r.data = 8'(cy);
                default: r.data = 8'h00;
            endcase
            rd_q.push_back(r);
        end

        if (e.ft) begin
            bg_lv = bg_sh;
            for (int k = 0; k < NP; k++) pal_lv[k] = pal_sh[k];
            fc = (fc + 1) % 128;
        end

        if (do_wr) begin
            case (a)
                0: bg_sh[23:16] = 8'(d);
                1: bg_sh[15:8]  = 8'(d);
                2: bg_sh[7:0]   = 8'(d);
                3: cx = d % 256;
                4: cy = d % 256;
                5: begin
                    if (cx < GW && cy < GH) begin
                        tmap[cy][cx]   = d % NP;
                        tknown[cy][cx] = 1;
                        cx++;
                        if (cx == GW) begin
                            cx = 0;
                            cy++;
                            if (cy == GH) cy = 0;
                        end
                    end else begin
                        cx = 0;
                        cy = 0;
                    end
                end
                6: pidx = d % NP;
                7: pal_sh[pidx][23:16] = 8'(d);
                8: pal_sh[pidx][15:8]  = 8'(d);
                9: pal_sh[pidx][7:0]   = 8'(d);
                default: ;
            endcase
        end

        chipselect = do_wr || do_rd;
        write      = do_wr;
        read       = do_rd;
        address    = 4'(a);
        writedata  = 8'(d);

        mh++;
        if (mh == HT) begin
            mh = 0;
            mv++;
            if (mv == VT) mv = 0;
        end
        cyc++;
    endtask

    task automatic tick(input bit do_wr, input bit do_rd, input int a, input int d);
        @(negedge clk);
        step(do_wr, do_rd, a, d);
    endtask

    task automatic idle(input int n);
        repeat (n) tick(0, 0, 0, 0);
    endtask

    task automatic wr_reg(input int a, input int d);
        tick(1, 0, a, d);
    endtask

    // Read whose expected value is a constant given by the caller.
    task automatic read_check(input int a, input logic [7:0] exp);
        rd_t r;
        tick(0, 1, a, 0);
        r = rd_q.pop_back();
        r.data = exp;
        rd_q.push_back(r);
    endtask

    task automatic run_to(input int v, input int h);
        for (int i = 0; i <= HT * VT && !(mh == h && mv == v); i++) idle(1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_r"},      32'(VGA_R), 32'h0);
        check({tag, "_g"},      32'(VGA_G), 32'h0);
        check({tag, "_b"},      32'(VGA_B), 32'h0);
        check({tag, "_hs"},     32'(VGA_HS), 32'h1);
        check({tag, "_vs"},     32'(VGA_VS), 32'h1);
        check({tag, "_blank"},  32'(VGA_BLANK_n), 32'h0);
        check({tag, "_rdata"},  32'(readdata), 32'h0);
        check({tag, "_tick"},   32'(frame_tick), 32'h0);
        check({tag, "_vclk"},   32'(VGA_CLK), 32'h0);
        check({tag, "_sync_n"}, 32'(VGA_SYNC_n), 32'h0);
    endtask

    task automatic reset_release();
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        pix_q.delete();
        rd_q.delete();
        cyc    = 0;
        mon_en = 1;
        step(0, 0, 0, 0);
    endtask

    // Monitor: frame_tick and VGA_CLK follow the counters directly, so they are
    // logged per cycle and compared with the entry that the pixel now leaving
    // the pipeline was predicted alongside.
    logic ft_hist [4];
    logic vc_hist [4];
    initial begin
        pix_t e;
        rd_t  r;
        forever begin
            @(posedge clk);
            #1;
            ft_hist[cyc % 4] = frame_tick;
            vc_hist[cyc % 4] = VGA_CLK;
            if (mon_en) begin
                while (pix_q.size() > 0 && pix_q[0].cyc < cyc - 2) begin
                    e = pix_q.pop_front();
                    check("pixel_missed", 32'(e.cyc), 32'(cyc - 2));
                end
                if (pix_q.size() > 0 && pix_q[0].cyc == cyc - 2) begin
                    e = pix_q.pop_front();
                    if (e.chk)
                        check("pixel", {5'h0, VGA_R, VGA_G, VGA_B, VGA_HS, VGA_VS, VGA_BLANK_n},
                              {5'h0, e.rgb, e.hs, e.vs, e.bn});
                    else
                        check("sync", {29'h0, VGA_HS, VGA_VS, VGA_BLANK_n},
                              {29'h0, e.hs, e.vs, e.bn});
                    check("tick_vclk", {30'h0, ft_hist[e.cyc % 4], vc_hist[e.cyc % 4]},
                          {30'h0, e.ft, e.vclk});
                end
                while (rd_q.size() > 0 && rd_q[0].due < cyc) begin
                    r = rd_q.pop_front();
                    check("read_missed", 32'(r.due), 32'(cyc));
                end
                if (rd_q.size() > 0 && rd_q[0].due == cyc) begin
                    r = rd_q.pop_front();
                    check($sformatf("read_a%0d", r.a), 32'(readdata), 32'(r.data));
                end
            end
        end
    end

    initial begin
        int r, a, d;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        reset_release();

        // Clear the map, then watch a full frame of raster timing.
        wr_reg(3, 0);
        wr_reg(4, 0);
        repeat (GW * GH) wr_reg(5, 0);
        idle(HT * VT);

        // Background written mid-frame appears only after the next commit.
        run_to(3, 4);
        wr_reg(0, 8'h11);
        wr_reg(1, 8'h22);
        wr_reg(2, 8'h33);
        idle(2 * HT * VT);

        // Cursor auto-increment across a row end.
        wr_reg(3, GW - 1);
        wr_reg(4, 0);
        wr_reg(5, 5);
        wr_reg(5, 5);
        read_check(11, 8'd1);
        read_check(12, 8'd1);
        idle(HT * VT);

        // Cursor wrap at the last cell, and an out-of-range cursor.
        wr_reg(3, GW - 1);
        wr_reg(4, GH - 1);
        wr_reg(5, 1);
        read_check(11, 8'd0);
        read_check(12, 8'd0);
        wr_reg(3, 50);
        wr_reg(4, 3);
        wr_reg(5, 7);
        read_check(11, 8'd0);
        read_check(12, 8'd0);

        // Palette entry 2 reprogrammed and used at the top-left cell.
        run_to(2, 0);
        wr_reg(6, 2);
        wr_reg(7, 8'h12);
        wr_reg(8, 8'h34);
        wr_reg(9, 8'h56);
        wr_reg(3, 0);
        wr_reg(4, 0);
        wr_reg(5, 2);
        idle(2 * HT * VT);

        // Random register traffic.
        for (int i = 0; i < 6000; i++) begin
            r = $urandom_range(0, 99);
            a = $urandom_range(0, 15);
            if (a == 3)      d = ($urandom_range(0, 9) == 0) ? 50 : $urandom_range(0, GW);
            else if (a == 4) d = ($urandom_range(0, 9) == 0) ? 50 : $urandom_range(0, GH);
            else             d = $urandom_range(0, 255);
            if (r < 20)      tick(1, 0, a, d);
            else if (r < 35) tick(0, 1, a, 0);
            else             idle(1);
        end

        // Frame counter across its 7-bit wrap, sampled in and out of vblank.
        for (int f = 0; f < 130; f++) begin
            run_to(2, 3);
            tick(0, 1, 10, 0);
            run_to(VA, 5);
            tick(0, 1, 10, 0);
        end

        // Reset asserted in the middle of an active line.
        wr_reg(3, 2);
        run_to(4, 6);
        tick(0, 1, 11, 0);
        idle(1);
        check("pre_reset_rdata", 32'(readdata), 32'd2);
        check("pre_reset_blank", 32'(VGA_BLANK_n), 32'd1);
        mon_en = 0;
        cyc    = 0;
        #2 reset = 1'b1;
        chipselect = 1'b0;
        write      = 1'b0;
        read       = 1'b0;
        #1;
        check_reset_outputs("midreset");
        repeat (3) @(negedge clk);
        reset_release();
        idle(HT * VT + 20);

        idle(4);
        mon_en = 0;
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
